// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command at a time to a registered ALU, waits
// for the matching class-valid flag (or a timeout / conflicting flags), and
// returns the selected result over a valid/ready response channel.
module alu_cmd_sequencer #(
    parameter int OP_DATA_WIDTH   = 16,
    parameter int ARITH_OUT_WIDTH = 32,
    parameter int TIMEOUT         = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic signed [OP_DATA_WIDTH-1:0]   cmd_a,
    input  logic signed [OP_DATA_WIDTH-1:0]   cmd_b,
    input  logic [3:0]                        cmd_fun,
    output logic [OP_DATA_WIDTH-1:0]          alu_a,
    output logic [OP_DATA_WIDTH-1:0]          alu_b,
    output logic [3:0]                        alu_fun,
    output logic                              alu_rst_n,
    input  logic signed [ARITH_OUT_WIDTH-1:0] arith_out,
    input  logic [15:0]                       logic_out,
    input  logic [15:0]                       cmp_out,
    input  logic [15:0]                       shift_out,
    input  logic                              arith_flag,
    input  logic                              logic_flag,
    input  logic                              cmp_flag,
    input  logic                              shift_flag,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ARITH_OUT_WIDTH-1:0]        rsp_data,
    output logic [3:0]                        rsp_fun,
    output logic                              rsp_err,
    output logic [15:0]                       op_count,
    output logic [7:0]                        err_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [OP_DATA_WIDTH-1:0]   alu_a_q, alu_b_q;
    logic [3:0]                 alu_fun_q;
    logic [ARITH_OUT_WIDTH-1:0] rsp_data_q;
    logic [3:0]                 rsp_fun_q;
    logic                       rsp_err_q;
    logic [CNT_W-1:0]           wait_cnt_q;
    logic [15:0]                op_count_q;
    logic [7:0]                 err_count_q;

    logic                       accept, rsp_fire;
    logic                       sel_flag, multi_flag, wait_armed;
    logic                       capture, give_up;
    logic [ARITH_OUT_WIDTH-1:0] sel_result;

    // Non-arithmetic ALU results are unsigned 16-bit quantities.
    function automatic logic [ARITH_OUT_WIDTH-1:0] zext16(input logic [15:0] v);
        return ARITH_OUT_WIDTH'(v);
    endfunction

    // Error statistic sticks at its maximum rather than wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign accept    = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign alu_rst_n = ~rst;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fun   = rsp_fun_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;
    assign err_count = err_count_q;

    // Flag/result selection uses the latched function so a changing cmd_fun
    // during WAIT cannot redirect the pending operation.
    always_comb begin
        sel_flag   = arith_flag;
        sel_result = arith_out;
        case (alu_fun_q[3:2])
            2'b01: begin
                sel_flag   = logic_flag;
                sel_result = zext16(logic_out);
            end
            2'b10: begin
                sel_flag   = cmp_flag;
                sel_result = zext16(cmp_out);
            end
            2'b11: begin
                sel_flag   = shift_flag;
                sel_result = zext16(shift_out);
            end
            default: begin
                sel_flag   = arith_flag;
                sel_result = arith_out;
            end
        endcase
        multi_flag = (arith_flag && logic_flag) || (arith_flag && cmp_flag) ||
                     (arith_flag && shift_flag) || (logic_flag && cmp_flag) ||
                     (logic_flag && shift_flag) || (cmp_flag && shift_flag);
        // The first WAIT cycle still sees the previous operation's flags.
        wait_armed = (wait_cnt_q != '0);
        capture    = wait_armed && sel_flag && !multi_flag;
        give_up    = (wait_armed && multi_flag) || (wait_cnt_q == TIMEOUT_CNT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = WAIT;
            WAIT:    if (capture || give_up) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    // Operand latch, wait counter, response capture and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            rsp_data_q  <= '0;
            rsp_fun_q   <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
            op_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            if (accept) begin
                alu_a_q    <= cmd_a;
                alu_b_q    <= cmd_b;
                alu_fun_q  <= cmd_fun;
                rsp_fun_q  <= cmd_fun;
                wait_cnt_q <= '0;
            end
            if (state_q == WAIT) begin
                if (capture) begin
                    rsp_data_q <= sel_result;
                    rsp_err_q  <= 1'b0;
                end else if (give_up) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end else begin
                    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                end
            end
            if (rsp_fire) begin
                op_count_q <= op_count_q + 16'd1;
                if (rsp_err_q) begin
                    err_count_q <= sat_inc8(err_count_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a registered ALU model with selectable flag
// behaviour drives the DUT; expected responses go into a scoreboard queue at
// command accept and are compared when the response handshake occurs.
module tb_alu_cmd_sequencer;

    localparam int TIMEOUT = 4;

    logic               clk;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [15:0] cmd_a, cmd_b;
    logic [3:0]         cmd_fun;
    logic [15:0]        alu_a, alu_b;
    logic [3:0]         alu_fun;
    logic               alu_rst_n;
    logic signed [31:0] arith_out;
    logic [15:0]        logic_out, cmp_out, shift_out;
    logic               arith_flag, logic_flag, cmp_flag, shift_flag;
    logic               rsp_valid, rsp_ready;
    logic [31:0]        rsp_data;
    logic [3:0]         rsp_fun;
    logic               rsp_err;
    logic [15:0]        op_count;
    logic [7:0]         err_count;

    // 0: normal, 1: flags stuck 0, 2: all flags high, 3: only a wrong-class flag
    int flag_mode;
    int n_checks;
    int n_pass;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  fun;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    alu_cmd_sequencer #(
        .OP_DATA_WIDTH(16),
        .ARITH_OUT_WIDTH(32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_rst_n(alu_rst_n),
        .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out),
        .shift_out(shift_out),
        .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag),
        .shift_flag(shift_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fun(rsp_fun), .rsp_err(rsp_err),
        .op_count(op_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU model: samples alu_* every cycle, one-hot class flag.
    always @(posedge clk) begin
        if (!alu_rst_n) begin
            arith_out  <= '0;
            logic_out  <= '0;
            cmp_out    <= '0;
            shift_out  <= '0;
            arith_flag <= 1'b0;
            logic_flag <= 1'b0;
            cmp_flag   <= 1'b0;
            shift_flag <= 1'b0;
        end else begin
            case (alu_fun[1:0])
                2'd0: arith_out <= $signed(alu_a) + $signed(alu_b);
                2'd1: arith_out <= $signed(alu_a) - $signed(alu_b);
                2'd2: arith_out <= $signed(alu_a) * $signed(alu_b);
                default: arith_out <= $signed(alu_a);
            endcase
            case (alu_fun[1:0])
                2'd0: logic_out <= alu_a & alu_b;
                2'd1: logic_out <= alu_a | alu_b;
                2'd2: logic_out <= alu_a ^ alu_b;
                default: logic_out <= ~(alu_a & alu_b);
            endcase
            case (alu_fun[1:0])
                2'd0: cmp_out <= {15'd0, alu_a == alu_b};
                2'd1: cmp_out <= {15'd0, $signed(alu_a) > $signed(alu_b)};
                2'd2: cmp_out <= {15'd0, $signed(alu_a) < $signed(alu_b)};
                default: cmp_out <= 16'd0;
            endcase
            case (alu_fun[1:0])
                2'd0: shift_out <= alu_a << alu_b[3:0];
                2'd1: shift_out <= alu_a >> alu_b[3:0];
                2'd2: shift_out <= 16'($signed(alu_a) >>> alu_b[3:0]);
                default: shift_out <= alu_a;
            endcase
            arith_flag <= (flag_mode == 2) || (flag_mode == 0 && alu_fun[3:2] == 2'd0)
                          || (flag_mode == 3 && alu_fun[3:2] == 2'd3);
            logic_flag <= (flag_mode == 2) || (flag_mode == 0 && alu_fun[3:2] == 2'd1)
                          || (flag_mode == 3 && alu_fun[3:2] == 2'd0);
            cmp_flag   <= (flag_mode == 2) || (flag_mode == 0 && alu_fun[3:2] == 2'd2)
                          || (flag_mode == 3 && alu_fun[3:2] == 2'd1);
            shift_flag <= (flag_mode == 2) || (flag_mode == 0 && alu_fun[3:2] == 2'd3)
                          || (flag_mode == 3 && alu_fun[3:2] == 2'd2);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: compare on the cycle whose next edge completes the handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_spurious_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("rsp_data", rsp_data, mon_e.data);
                check_eq("rsp_fun", {28'd0, rsp_fun}, {28'd0, mon_e.fun});
                check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
            end
        end
    end

    // Drive a command, wait for acceptance and record its expected response.
    task automatic issue_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                             input logic [31:0] ed, input logic ee);
        int t;
        cmd_a = a;
        cmd_b = b;
        cmd_fun = fun;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) check_eq("accept_timeout", {31'd0, cmd_ready}, 32'd1);
        sb.push_back('{ed, fun, ee});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Count edges from accept until rsp_valid rises.
    task automatic await_rsp(input int exp_lat);
        int t;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("latency", t, exp_lat);
    endtask

    task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                           input logic [31:0] ed, input logic ee, input int lat);
        issue_cmd(a, b, fun, ed, ee);
        await_rsp(lat);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        flag_mode = 0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_fun = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_alu_fun", {28'd0, alu_fun}, 32'd0);
        check_eq("rst_op_count", {16'd0, op_count}, 32'd0);
        check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("alu_rst_n_rel", {31'd0, alu_rst_n}, 32'd1);

        // Signed add, nominal latency
        run_cmd(-16'sd4, -16'sd5, 4'b0000, 32'hFFFF_FFF7, 1'b0, 2);
        check_eq("op_count_1", {16'd0, op_count}, 32'd1);

        // Back-to-back logic ops; the second must not pick up the stale first result
        run_cmd(16'd5, 16'd6, 4'b0100, 32'h0000_0004, 1'b0, 2);
        run_cmd(16'd5, 16'd6, 4'b0101, 32'h0000_0007, 1'b0, 2);

        // One of each class, including high-bit 16-bit results (zero-extended)
        run_cmd(16'd9, 16'd9, 4'b1000, 32'h0000_0001, 1'b0, 2);
        run_cmd(16'd3, 16'd2, 4'b1100, 32'h0000_000C, 1'b0, 2);
        run_cmd(-16'sd16, 16'd2, 4'b1110, 32'h0000_FFFC, 1'b0, 2);
        run_cmd(16'd5, 16'd6, 4'b0111, 32'h0000_FFFB, 1'b0, 2);
        run_cmd(16'd3, 16'd10, 4'b0001, 32'hFFFF_FFF9, 1'b0, 2);
        run_cmd(-16'sd300, 16'd200, 4'b0010, 32'hFFFF_15A0, 1'b0, 2);
        check_eq("op_count_9", {16'd0, op_count}, 32'd9);
        check_eq("err_count_0", {24'd0, err_count}, 32'd0);

        // Flags stuck low: timeout after TIMEOUT armed wait cycles
        flag_mode = 1;
        run_cmd(16'd1, 16'd2, 4'b1001, 32'd0, 1'b1, TIMEOUT + 1);
        check_eq("err_count_to", {24'd0, err_count}, 32'd1);
        // Several flags at once
        flag_mode = 2;
        run_cmd(16'd5, 16'd6, 4'b0000, 32'd0, 1'b1, 2);
        // Only a flag of another class: still a timeout
        flag_mode = 3;
        run_cmd(16'd5, 16'd6, 4'b0100, 32'd0, 1'b1, TIMEOUT + 1);
        flag_mode = 0;
        check_eq("err_count_3", {24'd0, err_count}, 32'd3);
        check_eq("op_count_12", {16'd0, op_count}, 32'd12);

        // Response back-pressure with a second command held on cmd_valid
        rsp_ready = 1'b0;
        issue_cmd(16'd16, 16'd4, 4'b0101, 32'h0000_0014, 1'b0);
        await_rsp(2);
        cmd_a = 16'd7;
        cmd_b = 16'd3;
        cmd_fun = 4'b0001;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("stall_data", rsp_data, 32'h0000_0014);
            check_eq("stall_fun", {28'd0, rsp_fun}, 32'd5);
            check_eq("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("hs_no_accept", {31'd0, cmd_ready}, 32'd1);
        check_eq("hs_alu_fun_held", {28'd0, alu_fun}, 32'd5);
        sb.push_back('{32'd4, 4'b0001, 1'b0});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq("accept_resume", {31'd0, cmd_ready}, 32'd0);
        check_eq("resume_alu_a", {16'd0, alu_a}, 32'd7);
        await_rsp(2);
        @(posedge clk); #1;
        check_eq("op_count_14", {16'd0, op_count}, 32'd14);

        // Reset while waiting: no response, everything back to reset values
        issue_cmd(16'd1, 16'd2, 4'b0000, 32'd3, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("wrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("wrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("wrst_rsp_data", rsp_data, 32'd0);
        check_eq("wrst_rsp_fun", {28'd0, rsp_fun}, 32'd0);
        check_eq("wrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("wrst_alu_a", {16'd0, alu_a}, 32'd0);
        check_eq("wrst_alu_b", {16'd0, alu_b}, 32'd0);
        check_eq("wrst_alu_fun", {28'd0, alu_fun}, 32'd0);
        check_eq("wrst_op_count", {16'd0, op_count}, 32'd0);
        check_eq("wrst_err_count", {24'd0, err_count}, 32'd0);
        check_eq("wrst_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("wrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // 256 forced errors: err_count saturates, op_count keeps counting
        flag_mode = 2;
        for (int i = 0; i < 256; i++) begin
            run_cmd(16'(i), 16'(i + 1), 4'(i), 32'd0, 1'b1, 2);
            if (i == 254) check_eq("err_count_255", {24'd0, err_count}, 32'd255);
        end
        flag_mode = 0;
        check_eq("err_count_sat", {24'd0, err_count}, 32'h0000_00FF);
        check_eq("op_count_256", {16'd0, op_count}, 32'd256);
        check_eq("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
